// File: rtl/execution_controller_pkg.sv
// Shared types and defaults for the execution controller slice.
package execution_controller_pkg;

   localparam int unsigned DEFAULT_QWIDTH      = 32;
   localparam int unsigned DEFAULT_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      STATE_RUN     = 2'd0,
      STATE_WAIT_IN = 2'd1,
      STATE_HALTED  = 2'd2
   } state_t;

endpackage

// File: rtl/execution_controller_button_sync_edge.sv
// Button synchroniser plus rising-edge detector: one pulse per press.
module button_sync_edge
   import execution_controller_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic clock,
   input  logic reset,
   input  logic Button,
   output logic btnRise_c
);

   logic [SYNC_STAGES-1:0] syncChain;
   logic                   prevSynced;

   if (SYNC_STAGES < 2) begin : gBadStages
      $error("button_sync_edge: SYNC_STAGES must be at least 2");
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         syncChain  <= '0;
         prevSynced <= 1'b0;
      end else begin
         syncChain  <= {syncChain[SYNC_STAGES-2:0], Button};
         prevSynced <= syncChain[SYNC_STAGES-1];
      end
   end

   assign btnRise_c = syncChain[SYNC_STAGES-1] & ~prevSynced;

endmodule

// File: rtl/execution_controller.sv
// Commit-enable generator: input stall, terminal halt and instruction-count preemption timer.
module execution_controller
   import execution_controller_pkg::*;
#(
   parameter int unsigned QWIDTH      = DEFAULT_QWIDTH,
   parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              Button,
   input  logic              EnableClock,
   input  logic              Halt,
   input  logic              setClock,
   input  logic              getInterruption,
   input  logic [QWIDTH-1:0] quantum,
   output logic              cpu_enable,
   output logic              irq_flag,
   output logic              waiting_input,
   output logic              halted
);

   state_t            state;
   state_t            nextState;
   logic              btnRise;
   logic [QWIDTH-1:0] counter;
   logic              armed;
   logic              expire;

   button_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) uButtonSync (
      .clock    (clock),
      .reset    (reset),
      .Button   (Button),
      .btnRise_c(btnRise)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= STATE_RUN;
      end else begin
         state <= nextState;
      end
   end

   // Halt wins over a concurrent wait request; HALTED is left only by reset.
   always_comb begin
      nextState = state;
      case (state)
         STATE_RUN: begin
            if (Halt) begin
               nextState = STATE_HALTED;
            end else if (!EnableClock) begin
               nextState = STATE_WAIT_IN;
            end
         end
         STATE_WAIT_IN: begin
            if (btnRise) begin
               nextState = STATE_RUN;
            end
         end
         STATE_HALTED: nextState = STATE_HALTED;
         default:      nextState = STATE_RUN;
      endcase
   end

   always_comb begin
      cpu_enable    = 1'b0;
      waiting_input = (state == STATE_WAIT_IN);
      halted        = (state == STATE_HALTED);
      if (!reset) begin
         case (state)
            STATE_RUN:     cpu_enable = EnableClock & ~Halt;
            STATE_WAIT_IN: cpu_enable = btnRise;
            default:       cpu_enable = 1'b0;
         endcase
      end
   end

   // A reload in the same cycle suppresses the expiry.
   assign expire = armed & ~setClock & (counter == QWIDTH'(1));

   // Timer and flag only move on committed instructions.
   always_ff @(posedge clock) begin
      if (reset) begin
         counter  <= '0;
         armed    <= 1'b0;
         irq_flag <= 1'b0;
      end else if (cpu_enable) begin
         if (setClock) begin
            if (quantum != '0) begin
               counter <= quantum;
               armed   <= 1'b1;
            end else begin
               armed   <= 1'b0;
            end
         end else if (armed && (counter != '0)) begin
            counter <= counter - QWIDTH'(1);
            if (counter == QWIDTH'(1)) begin
               armed <= 1'b0;
            end
         end
         if (expire) begin
            irq_flag <= 1'b1;
         end else if (getInterruption) begin
            irq_flag <= 1'b0;
         end
      end
   end

endmodule
